// File: rtl/memory_responder.sv
// Memory-mapped target: RAM, boot ROM and a small I/O block.
// Reads are registered with a fixed latency of 1 or 2 cycles; writes commit on the request edge.
module memory_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH = 8192,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE = 16'hE000,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE = 16'hF000,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR_ADDR_LOW = 16'hFFFC,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR_ADDR_HIGH = 16'hFFFD,
    parameter logic [15:0] RESET_VECTOR = 16'hF000,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] io_out,
    output logic                  mem_error
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RAM_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] IN_ADDR = IO_BASE + ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = IO_BASE + ADDR_WIDTH'(2);

    // Boot image: reset vector bytes, all other locations hold addr_lo ^ addr_hi.
    function automatic logic [DATA_WIDTH-1:0] rom_byte(input logic [ADDR_WIDTH-1:0] a);
        if (a == RESET_VECTOR_ADDR_LOW) return RESET_VECTOR[7:0];
        if (a == RESET_VECTOR_ADDR_HIGH) return RESET_VECTOR[15:8];
        return a[7:0] ^ a[15:8];
    endfunction

    logic [DATA_WIDTH-1:0] ram_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] io_out_q;
    logic [DATA_WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic                  in_changed_q, in_changed_d;
    logic                  mem_error_q, mem_error_d;
    logic [DATA_WIDTH-1:0] p1_data_q;
    logic                  p1_valid_q;

    logic sel_ram, sel_rom, sel_out, sel_in, sel_stat, mapped;
    logic rd_acc, wr_legal;
    logic [DATA_WIDTH-1:0] rd_data;

    assign sel_ram  = address_in <= RAM_LAST;
    assign sel_rom  = address_in >= ROM_BASE;
    assign sel_out  = address_in == IO_BASE;
    assign sel_in   = address_in == IN_ADDR;
    assign sel_stat = address_in == STAT_ADDR;
    assign mapped   = sel_ram | sel_rom | sel_out | sel_in | sel_stat;

    assign rd_acc   = mem_read & ~mem_write;
    assign wr_legal = sel_ram | sel_out;

    always_comb begin
        rd_data = '0;
        if (sel_ram) rd_data = ram_q[address_in[RAM_AW-1:0]];
        else if (sel_rom) rd_data = rom_byte(address_in);
        else if (sel_out) rd_data = io_out_q;
        else if (sel_in) rd_data = sync2_q;
        else if (sel_stat) rd_data = {{(DATA_WIDTH-2){1'b0}}, in_changed_q, mem_error_q};
    end

    // A change seen on the same edge as an IN read must not be lost.
    always_comb begin
        in_changed_d = in_changed_q & ~(rd_acc & sel_in);
        if (sync2_q != prev_q) in_changed_d = 1'b1;
        mem_error_d = mem_error_q;
        if (mem_read & mem_write) mem_error_d = 1'b1;
        if (mem_write & ~wr_legal) mem_error_d = 1'b1;
        if (rd_acc & ~mapped) mem_error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_write && sel_ram) begin
            ram_q[address_in[RAM_AW-1:0]] <= bus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io_out_q     <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            in_changed_q <= 1'b0;
            mem_error_q  <= 1'b0;
            p1_data_q    <= '0;
            p1_valid_q   <= 1'b0;
        end else begin
            sync1_q      <= io_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            in_changed_q <= in_changed_d;
            mem_error_q  <= mem_error_d;
            p1_valid_q   <= rd_acc;
            if (mem_write && sel_out) io_out_q <= bus_in;
            if (rd_acc) p1_data_q <= rd_data;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] p2_data_q;
            logic                  p2_valid_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    p2_data_q  <= '0;
                    p2_valid_q <= 1'b0;
                end else begin
                    p2_valid_q <= p1_valid_q;
                    if (p1_valid_q) p2_data_q <= p1_data_q;
                end
            end
            assign data_out   = p2_data_q;
            assign data_valid = p2_valid_q;
        end else begin : g_lat1
            assign data_out   = p1_data_q;
            assign data_valid = p1_valid_q;
        end
    endgenerate

    assign io_out    = io_out_q;
    assign mem_error = mem_error_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: latency-1 and latency-2 instances driven in lockstep
// and compared against a transaction-level model of the memory map.
module tb_memory_responder;

    logic        clk;
    logic        reset;
    logic [15:0] address_in;
    logic        mem_read, mem_write;
    logic [7:0]  bus_in, io_in, io_drv;
    logic [7:0]  do1, do2, io1, io2;
    logic        dv1, dv2, err1, err2;

    memory_responder #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .address_in(address_in),
        .mem_read(mem_read), .mem_write(mem_write), .bus_in(bus_in),
        .io_in(io_in), .data_out(do1), .data_valid(dv1),
        .io_out(io1), .mem_error(err1)
    );

    memory_responder #(.READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .address_in(address_in),
        .mem_read(mem_read), .mem_write(mem_write), .bus_in(bus_in),
        .io_in(io_in), .data_out(do2), .data_valid(dv2),
        .io_out(io2), .mem_error(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [7:0] d;
    } rd_t;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    // Reference state: memory map contents plus issued-read lists per latency.
    logic [7:0] ram_m [0:8191];
    logic [7:0] io_m, last1, last2;
    logic       err_m, chg_m;
    logic [7:0] hist [0:2];
    rd_t        q1[$], q2[$];

    function automatic logic [7:0] rom_img(input logic [15:0] a);
        logic [15:0] v;
        v = a;
        if (a == 16'hFFFC) return 8'h00;
        if (a == 16'hFFFD) return 8'hF0;
        return v[7:0] ^ v[15:8];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] rv;
        logic       set_chg, clr_chg, old_err, old_chg;
        if (reset) begin
            q1.delete();
            q2.delete();
            last1 = 8'h00;
            last2 = 8'h00;
            io_m = 8'h00;
            err_m = 1'b0;
            chg_m = 1'b0;
            for (int i = 0; i < 3; i++) hist[i] = 8'h00;
            return;
        end
        set_chg = (hist[1] != hist[2]);
        clr_chg = 1'b0;
        old_err = err_m;
        old_chg = chg_m;
        if (mem_write) begin
            if (address_in < 16'd8192) ram_m[address_in] = bus_in;
            else if (address_in == 16'hE000) io_m = bus_in;
            else err_m = 1'b1;
            if (mem_read) err_m = 1'b1;
        end else if (mem_read) begin
            rv = 8'h00;
            if (address_in < 16'd8192) rv = ram_m[address_in];
            else if (address_in >= 16'hF000) rv = rom_img(address_in);
            else if (address_in == 16'hE000) rv = io_m;
            else if (address_in == 16'hE001) begin
                rv = hist[1];
                clr_chg = 1'b1;
            end
            else if (address_in == 16'hE002) rv = {6'b0, old_chg, old_err};
            else err_m = 1'b1;
            q1.push_back('{e: edge_n, d: rv});
            q2.push_back('{e: edge_n + 1, d: rv});
        end
        chg_m = (clr_chg ? 1'b0 : chg_m) | set_chg;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = io_in;
    endtask

    task automatic check_all();
        logic ev1, ev2;
        ev1 = 1'b0;
        ev2 = 1'b0;
        if (q1.size() > 0 && q1[0].e == edge_n) begin
            ev1 = 1'b1;
            last1 = q1[0].d;
            void'(q1.pop_front());
        end
        if (q2.size() > 0 && q2[0].e == edge_n) begin
            ev2 = 1'b1;
            last2 = q2[0].d;
            void'(q2.pop_front());
        end
        chk("valid_l1", dv1, ev1);
        chk("data_l1", do1, last1);
        chk("io_out_l1", io1, io_m);
        chk("err_l1", err1, err_m);
        chk("valid_l2", dv2, ev2);
        chk("data_l2", do2, last2);
        chk("io_out_l2", io2, io_m);
        chk("err_l2", err2, err_m);
    endtask

    task automatic step(input logic rst, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = rst;
        mem_read = rd;
        mem_write = wr;
        address_in = a;
        bus_in = d;
        io_in = io_drv;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 6))
            0, 1: return 16'($urandom_range(0, 63));
            2: return 16'($urandom_range(16'hF000, 16'hFFFF));
            3: return 16'hE000 + 16'($urandom_range(0, 2));
            4: return 16'($urandom_range(16'h2000, 16'hDFFF));
            5: return ($urandom_range(0, 1) == 0) ? 16'hE003 : 16'h2000;
            default: return ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'hF000;
        endcase
    endfunction

    initial begin
        logic [3:0] op;
        reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        address_in = 16'h0000;
        bus_in = 8'h00;
        io_in = 8'h00;
        io_drv = 8'h00;

        do_reset();
        step(1'b0, 1'b1, 1'b0, 16'hFFFC, 8'h00);
        chk("rv_low_l1", do1, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'hFFFD, 8'h00);
        chk("rv_high_l1", do1, 16'h00F0);
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00);
        idle(2);

        step(1'b0, 1'b0, 1'b1, 16'h0010, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        chk("raw_a5_l1", do1, 16'h00A5);
        idle(2);

        step(1'b0, 1'b0, 1'b1, 16'h0000, 8'h11);
        step(1'b0, 1'b0, 1'b1, 16'h0001, 8'h22);
        step(1'b0, 1'b0, 1'b1, 16'h0002, 8'h33);
        step(1'b0, 1'b0, 1'b1, 16'h0003, 8'h44);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'(i), 8'h00);
        idle(2);

        step(1'b0, 1'b0, 1'b1, 16'hE000, 8'h3C);
        chk("io_out_3c", io1, 16'h003C);
        step(1'b0, 1'b0, 1'b1, 16'hF100, 8'h77);
        step(1'b0, 1'b1, 1'b0, 16'hF100, 8'h00);
        chk("rom_kept", do1, 16'h00F1);
        idle(3);
        chk("err_sticky", err2, 16'h0001);
        do_reset();

        io_drv = 8'h5A;
        idle(4);
        step(1'b0, 1'b1, 1'b0, 16'hE002, 8'h00);
        chk("status_chg", do1, 16'h0002);
        step(1'b0, 1'b1, 1'b0, 16'hE001, 8'h00);
        chk("in_5a", do1, 16'h005A);
        step(1'b0, 1'b1, 1'b0, 16'hE002, 8'h00);
        chk("status_clr", do1, 16'h0000);
        idle(2);

        step(1'b0, 1'b1, 1'b1, 16'h0020, 8'h99);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 16'h0020, 8'h00);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 16'hFFFD, 8'h00);
        step(1'b1, 1'b1, 1'b0, 16'hFFFC, 8'h00);
        chk("rst_mid_l2", dv2, 16'h0000);
        idle(2);

        for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, 16'(i), 8'($urandom));
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) io_drv = 8'($urandom);
            op = 4'($urandom_range(0, 9));
            if (n % 150 == 149) step(1'b1, 1'b1, 1'b0, rand_addr(), 8'h00);
            else if (op < 4) step(1'b0, 1'b1, 1'b0, rand_addr(), 8'h00);
            else if (op < 7) step(1'b0, 1'b0, 1'b1, rand_addr(), 8'($urandom));
            else if (op == 7) step(1'b0, 1'b1, 1'b1, rand_addr(), 8'($urandom));
            else idle(1);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
